alipi_logit_approx: RTL and testbench
=====================================

# alipi_logit_approx

Sequential inverse of the team's piecewise sigmoid approximator. Takes a probability in Q8.8 and returns the Q8.8 argument that the forward approximator maps to it. It sits downstream of the sigmoid output path, for calibration and round-trip checks. It normalises the operand one shift per cycle behind a valid/ready handshake on both sides.

## Interface
- `SAT_POS`, default 16'h7FFF: result for Y ≥ 1.0.
- `SAT_NEG`, default 16'h8000: result for Y ≤ 0 or negative Y.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design enable. Low forces the FSM to IDLE and clears the outputs on the next edge.
- `in_y`  in  16  probability, Q8.8 two's complement.
- `in_valid`  in  1  `in_y` is valid.
- `in_ready`  out  1  block accepts `in_y`; high only in IDLE with `ena` high.
- `out_x`  out  16  result, Q8.8 two's complement, registered.
- `out_valid`  out  1  `out_x` is valid.
- `out_ready`  in  1  consumer accepts `out_x`.
- `busy`  out  1  high in NORM or DONE.

## Operation
- Input accept: `in_valid && in_ready` at a rising edge.
- Classification on accept (Y = `in_y`):
  - Y[15]=1 or Y=0: result `SAT_NEG`; go to DONE.
  - Y ≥ 0x0100: result `SAT_POS`; go to DONE.
  - 0x0041 ≤ Y ≤ 0x007F: result 0x0000 (dead zone; the forward map jumps from 64/256 to 128/256 at x=0); go to DONE.
  - Y ≥ 0x0080 (positive side): load g = 0x0100 − Y (range 1..128), n = 0; go to NORM. The normalisation target is g ≥ 128.
  - 1 ≤ Y ≤ 0x0040 (negative side): load g = Y, n = 0; go to NORM. The normalisation target is g > 64.
- NORM, each cycle:
  - Target not met: g ← g<<1 and n ← n+1, both 8-bit.
  - Target met: register the result and go to DONE.
- Result, positive side:
  - f = (g − 128)<<2, saturated to 0xFF when g ≥ 192.
  - X = {n, f}.
- Result, negative side:
  - f = (128 − g)<<2, range 0..252.
  - X = {~n, f} + 16'h0100, computed mod 2^16.
- n never exceeds 7. Worst case is Y=0x0001 or Y=0x00FF.
- DONE: hold `out_valid` high and `out_x` stable until `out_ready` is seen high at an edge, then return to IDLE.
- FSM states: IDLE → NORM | DONE; NORM → NORM | DONE; DONE → IDLE.
- When `ena` is low in any state: go to IDLE, set `out_valid` to 0 and `out_x` to 0. The operation in flight is discarded.

## Timing
- Reset values: `out_x`=0, `out_valid`=0, `in_ready`=1 once `rst_n` is released with `ena` high, `busy`=0, FSM in IDLE.
- Latency from the accept edge to `out_valid`:
  - 1 cycle for saturation and dead-zone inputs.
  - n+2 cycles for the normalising path: one load edge, n shift edges, one result edge. Worst case is 9 cycles.
- No pipelining: one operation in flight at a time. `in_ready` is low from the accept edge until the edge that consumes the result.
- `out_ready` may already be high when `out_valid` rises. In that case the result is consumed at the next edge, and `in_ready` rises the cycle after.
- `in_y` is sampled only at the accept edge; later changes are ignored.
- Asynchronous reset mid-operation aborts immediately. Outputs go to their reset values with no edge required.

## Structure
- Shared package `alipi_sigmoid_pkg`, also used by the forward approximator, holds:
  - state enum {IDLE, NORM, DONE};
  - Q8.8 constants ONE=16'h0100, HALF=16'h0080, QUARTER=16'h0040;
  - default saturation values.
- One sub-module, `logit_result_fmt`: a combinational block mapping (side, n, g) to the Q8.8 result, including clamping and two's-complement reconstruction.
- The FSM, the g/n registers and the handshake stay in the top module.

## Test plan
- Y=0x0080 → X=0x0000 with `out_valid` 2 cycles after accept. Y=0x00C0 → X=0x0100 after 3 cycles. Y=0x00E0 → X=0x0200 after 4 cycles.
- Y=0x00D0 → X=0x02FF (f clamped). Y=0x00FF → X=0x0700 after 9 cycles.
- Negative side:
  - Y=0x0040 → X=0xFF00.
  - Y=0x0030 → X=0xFF80.
  - Y=0x0001 → X=0xF900 after 9 cycles.
- Y=0x0000 or 0x8123 → 0x8000. Y=0x0100 or 0x7FFF → 0x7FFF. Y=0x0060 → 0x0000. Each with 1-cycle latency.
- Hold `out_ready` low for 5 cycles in DONE: `out_x` stays stable and `in_ready` stays low. Raise `out_ready`: IDLE next cycle, and a back-to-back Y=0x0080 is accepted.
- Mid-NORM cases:
  - Drop `ena` → IDLE, `out_x`=0, no `out_valid`.
  - Assert `rst_n` low → outputs reset asynchronously.
- Round-trip: for every x with forward(x) in 0x0001..0x0040 or 0x0080..0x00FF, inverse(forward(x)) re-applied through forward reproduces forward(x) exactly.

Source files
------------

// File: rtl/alipi_sigmoid_pkg.sv
// alipi_sigmoid_pkg: shared state encoding and Q8.8 constants for the sigmoid/logit blocks
package alipi_sigmoid_pkg;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  localparam logic [15:0] ONE = 16'h0100;
  localparam logic [15:0] HALF = 16'h0080;
  localparam logic [15:0] QUARTER = 16'h0040;
  localparam logic [15:0] DEF_SAT_POS = 16'h7FFF;
  localparam logic [15:0] DEF_SAT_NEG = 16'h8000;
endpackage

// File: rtl/alipi_logit_approx_if.sv
// alipi_logit_approx_if: probability-in / argument-out valid-ready handshake
interface alipi_logit_approx_if;
  logic [15:0] in_y;
  logic in_valid;
  logic in_ready;
  logic [15:0] out_x;
  logic out_valid;
  logic out_ready;
  modport master(output in_y, in_valid, out_ready, input in_ready, out_x, out_valid);
  modport slave(input in_y, in_valid, out_ready, output in_ready, out_x, out_valid);
endinterface

// File: rtl/alipi_logit_approx_fmt.sv
// logit_result_fmt: maps normalised (side, n, g) to the Q8.8 logit result
module logit_result_fmt
  import alipi_sigmoid_pkg::*;
(
  input  logic        side,
  input  logic [7:0]  n,
  input  logic [7:0]  g,
  output logic [15:0] x
);
  logic [7:0] d, pos_f, neg_f;
  always_comb begin
    d = 8'd128 - g;
    pos_f = (g[7:6] == 2'b11) ? 8'hFF : {g[5:0], 2'b00};
    neg_f = {d[5:0], 2'b00};
    x = side ? {~n, neg_f} + ONE : {n, pos_f};
  end
endmodule

// File: rtl/alipi_logit_approx.sv
// alipi_logit_approx: sequential inverse of the piecewise sigmoid, one normalising shift per cycle
module alipi_logit_approx
  import alipi_sigmoid_pkg::*;
#(
  parameter logic [15:0] SAT_POS = DEF_SAT_POS,
  parameter logic [15:0] SAT_NEG = DEF_SAT_NEG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic busy,
  alipi_logit_approx_if.slave bus
);
  state_t state, state_n;
  logic [7:0] g, g_n, n, n_n;
  logic side, side_n, v, v_n, met;
  logic [15:0] x, x_n, fmt_x, y;
  logit_result_fmt u_fmt (.side(side), .n(n), .g(g), .x(fmt_x));
  assign y = bus.in_y;
  // negative side stops once g exceeds a quarter, positive side once g reaches a half
  assign met = side ? (g > QUARTER[7:0]) : g[7];
  assign bus.in_ready = (state == IDLE) && ena;
  assign bus.out_x = x;
  assign bus.out_valid = v;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    g_n = g;
    n_n = n;
    side_n = side;
    x_n = x;
    v_n = v;
    if (!ena) begin
      state_n = IDLE;
      x_n = '0;
      v_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state_n = DONE;
          v_n = 1'b1;
          if (y[15] || y == '0) x_n = SAT_NEG;
          else if (y >= ONE) x_n = SAT_POS;
          else if (y > QUARTER && y < HALF) x_n = '0;
          else begin
            state_n = NORM;
            v_n = 1'b0;
            side_n = y < HALF;
            g_n = (y < HALF) ? y[7:0] : 8'(ONE - y);
            n_n = '0;
          end
        end
        NORM: if (met) begin
          x_n = fmt_x;
          v_n = 1'b1;
          state_n = DONE;
        end else begin
          g_n = g << 1;
          n_n = n + 8'd1;
        end
        DONE: if (bus.out_ready) begin
          v_n = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      n <= '0;
      side <= 1'b0;
      x <= '0;
      v <= 1'b0;
    end else begin
      state <= state_n;
      g <= g_n;
      n <= n_n;
      side <= side_n;
      x <= x_n;
      v <= v_n;
    end
  end
endmodule

// File: tb/tb_alipi_logit_approx.sv
// tb_alipi_logit_approx: directed and swept checks of the Q8.8 logit approximator
module tb_alipi_logit_approx;
  logic clk = 0, rst_n = 0, ena = 1, busy;
  int pass_cnt = 0, total = 0;
  alipi_logit_approx_if bus();
  alipi_logit_approx dut (.clk(clk), .rst_n(rst_n), .ena(ena), .busy(busy), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_op(input logic [15:0] y, output logic [15:0] x, output int lat);
    bus.in_y = y;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    x = bus.out_x;
  endtask

  task automatic consume();
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
  endtask

  task automatic test_reset();
    bus.in_y = 16'h1234; bus.in_valid = 0; bus.out_ready = 0;
    rst_n = 0;
    #12;
    total++; if (bus.out_x !== 16'h0000) $display("FAIL reset_out_x actual=%h required=0000", bus.out_x); else pass_cnt++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else pass_cnt++;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready actual=%b required=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [15:0] ty[13] = '{16'h0080, 16'h00C0, 16'h00E0, 16'h00D0, 16'h00FF, 16'h0040, 16'h0030,
                            16'h0001, 16'h0000, 16'h8123, 16'h0100, 16'h7FFF, 16'h0060};
    logic [15:0] tx[13] = '{16'h0000, 16'h0100, 16'h0200, 16'h02FF, 16'h0700, 16'hFF00, 16'hFF80,
                            16'hF900, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000};
    int tl[13] = '{2, 3, 4, 4, 9, 3, 3, 9, 1, 1, 1, 1, 1};
    logic [15:0] x;
    int lat;
    for (int i = 0; i < 13; i++) begin
      do_op(ty[i], x, lat);
      total++; if (x !== tx[i]) $display("FAIL directed_x y=%h actual=%h required=%h", ty[i], x, tx[i]); else pass_cnt++;
      total++; if (lat != tl[i]) $display("FAIL directed_lat y=%h actual=%0d required=%0d", ty[i], lat, tl[i]); else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    int lat;
    int bad = 0;
    do_op(16'h00C0, x, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_x !== 16'h0100 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    total++; if (bad != 0) $display("FAIL hold_stable actual=%0d_bad_cycles required=0 out_x=%h", bad, bus.out_x); else pass_cnt++;
    consume();
    total++; if (bus.in_ready !== 1'b1) $display("FAIL hold_release_in_ready actual=%b required=1", bus.in_ready); else pass_cnt++;
    do_op(16'h0080, x, lat);
    total++; if (x !== 16'h0000 || lat != 2) $display("FAIL back_to_back actual=%h/%0d required=0000/2", x, lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_ena_drop();
    logic [15:0] x;
    int lat;
    do_op(16'h00FF, x, lat);
    consume();
    bus.in_y = 16'h0001; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL ena_busy_before actual=%b required=1", busy); else pass_cnt++;
    ena = 0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL ena_busy actual=%b required=0", busy); else pass_cnt++;
    total++; if (bus.out_x !== 16'h0000) $display("FAIL ena_out_x actual=%h required=0000", bus.out_x); else pass_cnt++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL ena_in_ready actual=%b required=0", bus.in_ready); else pass_cnt++;
    ena = 1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL ena_after actual=%b/%b required=0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [15:0] x;
    int lat;
    do_op(16'h00E0, x, lat);
    consume();
    bus.in_y = 16'h00FF; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++; if (bus.out_x !== 16'h0000) $display("FAIL areset_out_x actual=%h required=0000", bus.out_x); else pass_cnt++;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL areset_busy_valid actual=%b/%b required=0/0", busy, bus.out_valid); else pass_cnt++;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] model_x(input int y, output int lat);
    int g, n, f;
    n = 0;
    if (y >= 128) begin
      g = 256 - y;
      while (g < 128) begin g = g * 2; n++; end
      f = (g >= 192) ? 255 : (g - 128) * 4;
      model_x = 16'(n * 256 + f);
    end else begin
      g = y;
      while (g <= 64) begin g = g * 2; n++; end
      f = (128 - g) * 4;
      model_x = 16'((255 - n) * 256 + f + 256);
    end
    lat = n + 2;
  endfunction

  task automatic test_sweep();
    logic [15:0] x, ex;
    int lat, el;
    for (int y = 1; y < 256; y++) begin
      if (y > 64 && y < 128) continue;
      ex = model_x(y, el);
      do_op(16'(y), x, lat);
      total++; if (x !== ex || lat != el) $display("FAIL sweep y=%h actual=%h/%0d required=%h/%0d", y, x, lat, ex, el); else pass_cnt++;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ena_drop();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
